// File: rtl/wb_ssram_arb_if.sv
// Wishbone bus bundle shared by the two masters and the SSRAM slave port of wb_ssram_arb.
// din carries write data toward the slave and dout carries read data back.
interface wb_ssram_arb_if;
  logic [31:0] adr;
  logic [31:0] din;
  logic [31:0] dout;
  logic [3:0]  sel;
  logic        cyc;
  logic        stb;
  logic        we;
  logic        ack;
  logic        err;
  logic        rty;

  modport master (
    output adr, din, sel, cyc, stb, we,
    input  dout, ack, err, rty
  );

  modport slave (
    input  adr, din, sel, cyc, stb, we,
    output dout, ack, err, rty
  );
endinterface

// File: rtl/wb_ssram_arb.sv
// Two-master round-robin Wishbone arbiter in front of an SSRAM slave, with a
// stall timeout that errors the owner and drains the slave before release.
module wb_ssram_arb #(
  parameter int TMO_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  wb_ssram_arb_if.slave       m0,
  wb_ssram_arb_if.slave       m1,
  wb_ssram_arb_if.master      s,
  output logic [1:0]          gnt
);

  typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;

  localparam logic [TMO_W-1:0] CNT_ONE = TMO_W'(1);
  localparam logic [TMO_W-1:0] CNT_ALL = '1;
  localparam logic [TMO_W-1:0] CNT_PRE = CNT_ALL - CNT_ONE;

  state_t           state;
  logic             last;
  logic             armed;
  logic             tmo_err;
  logic [TMO_W-1:0] cnt;

  logic req0, req1, busy, term, g_cyc, g_stb;

  assign req0  = m0.cyc & m0.stb;
  assign req1  = m1.cyc & m1.stb;
  assign busy  = (state == BUSY);
  assign term  = s.ack | s.err | s.rty;
  assign g_cyc = gnt[1] ? m1.cyc : m0.cyc;
  assign g_stb = gnt[1] ? m1.stb : m0.stb;

  assign s.adr = busy ? (gnt[1] ? m1.adr : m0.adr) : '0;
  assign s.din = busy ? (gnt[1] ? m1.din : m0.din) : '0;
  assign s.sel = busy ? (gnt[1] ? m1.sel : m0.sel) : '0;
  assign s.we  = busy & (gnt[1] ? m1.we : m0.we);
  assign s.cyc = busy & g_cyc;
  assign s.stb = busy & g_stb;

  // The timeout err pulse lands in the first DRAIN cycle, while gnt still names the owner.
  assign m0.dout = s.dout;
  assign m1.dout = s.dout;
  assign m0.ack  = busy & gnt[0] & s.ack;
  assign m1.ack  = busy & gnt[1] & s.ack;
  assign m0.rty  = busy & gnt[0] & s.rty;
  assign m1.rty  = busy & gnt[1] & s.rty;
  assign m0.err  = gnt[0] & ((busy & s.err) | tmo_err);
  assign m1.err  = gnt[1] & ((busy & s.err) | tmo_err);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      gnt     <= 2'b00;
      last    <= 1'b1;
      armed   <= 1'b0;
      tmo_err <= 1'b0;
      cnt     <= '0;
    end else begin
      armed   <= 1'b1;
      tmo_err <= 1'b0;
      case (state)
        IDLE: begin
          if (armed && (req0 || req1)) begin
            state <= BUSY;
            cnt   <= '0;
            gnt   <= (req0 && (!req1 || last)) ? 2'b01 : 2'b10;
          end
        end
        BUSY: begin
          if (!g_cyc) begin
            state <= IDLE;
            gnt   <= 2'b00;
            last  <= gnt[1];
            cnt   <= '0;
          end else if (term) begin
            cnt <= '0;
          end else if (g_stb) begin
            // This stalled cycle would take the count to all-ones: time out now.
            if (cnt == CNT_PRE) begin
              state   <= DRAIN;
              tmo_err <= 1'b1;
              cnt     <= '0;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
        end
        DRAIN: begin
          if (term || cnt == CNT_PRE) begin
            state <= IDLE;
            gnt   <= 2'b00;
            last  <= gnt[1];
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= 2'b00;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_ssram_arb.sv
// Directed bench for wb_ssram_arb (TMO_W=4) with a transaction-level reference
// model compared against the DUT outputs on every falling clock edge.
module tb_wb_ssram_arb;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] gnt;

  wb_ssram_arb_if m0_bus ();
  wb_ssram_arb_if m1_bus ();
  wb_ssram_arb_if s_bus ();

  wb_ssram_arb #(.TMO_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .m0    (m0_bus),
    .m1    (m1_bus),
    .s     (s_bus),
    .gnt   (gnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference model: who owns the slave, whether it is being drained, and run lengths.
  int owner = -1;
  bit draining = 1'b0;
  bit err_due = 1'b0;
  int stall = 0;
  int last_served = 1;
  int edges = 0;

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic bit m_cyc(input int n);
    return (n == 1) ? m1_bus.cyc : m0_bus.cyc;
  endfunction

  function automatic bit m_stb(input int n);
    return (n == 1) ? m1_bus.stb : m0_bus.stb;
  endfunction

  task automatic release_owner();
    last_served = owner;
    owner = -1;
    draining = 1'b0;
    stall = 0;
  endtask

  task automatic model_step();
    bit r0, r1, term;
    r0 = m0_bus.cyc && m0_bus.stb;
    r1 = m1_bus.cyc && m1_bus.stb;
    term = s_bus.ack || s_bus.err || s_bus.rty;
    edges++;
    err_due = 1'b0;
    if (owner < 0) begin
      if (edges >= 2 && (r0 || r1)) begin
        owner = (r0 && r1) ? (1 - last_served) : (r0 ? 0 : 1);
        stall = 0;
      end
    end else if (!draining) begin
      if (!m_cyc(owner)) release_owner();
      else if (term) stall = 0;
      else if (m_stb(owner)) begin
        stall++;
        if (stall == 15) begin
          draining = 1'b1;
          err_due = 1'b1;
          stall = 0;
        end
      end
    end else begin
      stall++;
      if (term || stall == 15) release_owner();
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner = -1;
      draining = 1'b0;
      err_due = 1'b0;
      stall = 0;
      last_served = 1;
      edges = 0;
    end else begin
      model_step();
    end
  end

  task automatic compare_cycle();
    bit serving;
    logic [1:0]  e_gnt;
    logic [72:0] e_bus;
    logic [5:0]  e_term;
    serving = (owner >= 0) && !draining;
    e_gnt = (owner < 0) ? 2'b00 : ((owner == 0) ? 2'b01 : 2'b10);
    e_bus = '0;
    if (serving && owner == 0)
      e_bus = {m0_bus.adr, m0_bus.din, m0_bus.sel, m0_bus.cyc, m0_bus.stb, m0_bus.we};
    else if (serving && owner == 1)
      e_bus = {m1_bus.adr, m1_bus.din, m1_bus.sel, m1_bus.cyc, m1_bus.stb, m1_bus.we};
    e_term = {serving && owner == 0 && s_bus.ack,
              owner == 0 && ((serving && s_bus.err) || err_due),
              serving && owner == 0 && s_bus.rty,
              serving && owner == 1 && s_bus.ack,
              owner == 1 && ((serving && s_bus.err) || err_due),
              serving && owner == 1 && s_bus.rty};
    checkOutput("gnt", 128'(gnt), 128'(e_gnt));
    checkOutput("s_bus", 128'({s_bus.adr, s_bus.din, s_bus.sel, s_bus.cyc, s_bus.stb, s_bus.we}), 128'(e_bus));
    checkOutput("term", 128'({m0_bus.ack, m0_bus.err, m0_bus.rty, m1_bus.ack, m1_bus.err, m1_bus.rty}), 128'(e_term));
    checkOutput("dout", 128'({m0_bus.dout, m1_bus.dout}), 128'({s_bus.dout, s_bus.dout}));
  endtask

  always @(negedge clk) compare_cycle();

  task automatic applyStimulus(input int n, input bit cyc, input bit stb, input bit we, input logic [31:0] adr);
    if (n == 0) begin
      m0_bus.cyc = cyc; m0_bus.stb = stb; m0_bus.we = we;
      m0_bus.adr = adr; m0_bus.din = adr ^ 32'h5A5A_0000; m0_bus.sel = 4'hF;
    end else begin
      m1_bus.cyc = cyc; m1_bus.stb = stb; m1_bus.we = we;
      m1_bus.adr = adr; m1_bus.din = ~adr; m1_bus.sel = 4'h3;
    end
  endtask

  task automatic respond(input bit ack, input bit err, input bit rty);
    s_bus.ack = ack;
    s_bus.err = err;
    s_bus.rty = rty;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      s_bus.dout = s_bus.dout + 32'h0001_0203;
    end
  endtask

  initial begin
    s_bus.dout = 32'h1234_0000;
    respond(0, 0, 0);
    applyStimulus(0, 0, 0, 0, 32'h0);
    applyStimulus(1, 0, 0, 0, 32'h0);
    step(3);
    checkOutput("reset_gnt", 128'(gnt), 128'(2'b00));
    checkOutput("reset_stb", 128'(s_bus.stb), 128'(1'b0));

    // Lone m0 read: no grant on the first edge after reset, grant on the second.
    applyStimulus(0, 1, 1, 0, 32'h100);
    rst_n = 1'b1;
    step(1);
    checkOutput("first_edge_gnt", 128'(gnt), 128'(2'b00));
    step(1);
    checkOutput("m0_grant", 128'(gnt), 128'(2'b01));
    checkOutput("m0_adr", 128'(s_bus.adr), 128'(32'h100));
    respond(1, 0, 0);
    #1;
    checkOutput("m0_ack", 128'(m0_bus.ack), 128'(1'b1));
    checkOutput("m1_ack_quiet", 128'(m1_bus.ack), 128'(1'b0));
    step(1);
    respond(0, 0, 0);
    applyStimulus(0, 0, 0, 0, 32'h0);
    step(1);
    checkOutput("m0_release", 128'(gnt), 128'(2'b00));

    // Tie after reset goes to m0, then alternation.
    rst_n = 1'b0;
    step(2);
    applyStimulus(0, 1, 1, 0, 32'h1000);
    applyStimulus(1, 1, 1, 1, 32'h2000);
    rst_n = 1'b1;
    step(2);
    checkOutput("tie_m0", 128'(gnt), 128'(2'b01));
    applyStimulus(0, 0, 0, 0, 32'h0);
    step(1);
    checkOutput("m0_drop", 128'(gnt), 128'(2'b00));
    step(1);
    checkOutput("m1_after_m0", 128'(gnt), 128'(2'b10));
    respond(0, 0, 1);
    #1;
    checkOutput("m1_rty", 128'(m1_bus.rty), 128'(1'b1));
    checkOutput("m0_rty_quiet", 128'(m0_bus.rty), 128'(1'b0));
    step(1);
    respond(0, 0, 0);
    applyStimulus(0, 1, 1, 0, 32'h1004);
    applyStimulus(1, 0, 0, 0, 32'h0);
    step(1);
    checkOutput("m1_drop", 128'(gnt), 128'(2'b00));
    applyStimulus(1, 1, 1, 1, 32'h2004);
    step(1);
    checkOutput("alt_m0", 128'(gnt), 128'(2'b01));
    applyStimulus(0, 0, 0, 0, 32'h0);
    step(1);
    applyStimulus(0, 1, 1, 0, 32'h1008);
    step(1);
    checkOutput("tie_m1", 128'(gnt), 128'(2'b10));
    applyStimulus(0, 0, 0, 0, 32'h0);
    applyStimulus(1, 0, 0, 0, 32'h0);
    step(2);

    // m1 keeps cyc across three writes while m0 waits.
    applyStimulus(1, 1, 1, 1, 32'h3000);
    step(1);
    checkOutput("lock_grant", 128'(gnt), 128'(2'b10));
    applyStimulus(0, 1, 1, 0, 32'h4000);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 1, 1, 1, 32'h3000 + 32'(4 * k));
      respond(1, 0, 0);
      #1;
      checkOutput("lock_ack", 128'(m1_bus.ack), 128'(1'b1));
      checkOutput("lock_gnt", 128'(gnt), 128'(2'b10));
      checkOutput("lock_m0_idle", 128'(m0_bus.ack), 128'(1'b0));
      step(1);
      respond(0, 0, 0);
      applyStimulus(1, 1, 0, 1, 32'h3000);
      step(1);
    end
    applyStimulus(1, 0, 0, 0, 32'h0);
    step(1);
    checkOutput("lock_release", 128'(gnt), 128'(2'b00));
    step(1);
    checkOutput("lock_m0_after", 128'(gnt), 128'(2'b01));
    applyStimulus(0, 0, 0, 0, 32'h0);
    step(2);

    // Slave never answers: err pulse after 15 stalled cycles, then a 15-cycle drain.
    applyStimulus(0, 1, 1, 0, 32'h5000);
    step(1);
    checkOutput("tmo_grant", 128'(gnt), 128'(2'b01));
    step(14);
    checkOutput("tmo_not_yet", 128'(m0_bus.err), 128'(1'b0));
    checkOutput("tmo_stb_live", 128'(s_bus.stb), 128'(1'b1));
    step(1);
    checkOutput("tmo_err_pulse", 128'(m0_bus.err), 128'(1'b1));
    checkOutput("drain_stb", 128'(s_bus.stb), 128'(1'b0));
    checkOutput("drain_gnt", 128'(gnt), 128'(2'b01));
    applyStimulus(0, 0, 0, 0, 32'h0);
    step(1);
    checkOutput("tmo_err_once", 128'(m0_bus.err), 128'(1'b0));
    step(13);
    checkOutput("drain_hold", 128'(gnt), 128'(2'b01));
    step(1);
    checkOutput("drain_exit", 128'(gnt), 128'(2'b00));

    // Ack on the 15th stalled cycle beats the timeout.
    applyStimulus(0, 1, 1, 0, 32'h6000);
    step(1);
    step(14);
    respond(1, 0, 0);
    #1;
    checkOutput("race_ack", 128'(m0_bus.ack), 128'(1'b1));
    checkOutput("race_err", 128'(m0_bus.err), 128'(1'b0));
    step(1);
    respond(0, 0, 0);
    #1;
    checkOutput("race_no_pulse", 128'(m0_bus.err), 128'(1'b0));
    checkOutput("race_busy", 128'(gnt), 128'(2'b01));
    applyStimulus(0, 0, 0, 0, 32'h0);
    step(2);

    // A slave ack during drain ends the drain early and is not forwarded.
    applyStimulus(1, 1, 1, 0, 32'h7000);
    step(1);
    checkOutput("drain2_grant", 128'(gnt), 128'(2'b10));
    step(15);
    checkOutput("drain2_err", 128'(m1_bus.err), 128'(1'b1));
    applyStimulus(1, 0, 0, 0, 32'h0);
    step(2);
    respond(1, 0, 0);
    #1;
    checkOutput("drain_ack_blocked", 128'(m1_bus.ack), 128'(1'b0));
    step(1);
    respond(0, 0, 0);
    checkOutput("drain_ack_exit", 128'(gnt), 128'(2'b00));

    // Reset asserted mid-transfer clears everything at once.
    applyStimulus(1, 1, 1, 0, 32'h8000);
    step(1);
    checkOutput("pre_rst_grant", 128'(gnt), 128'(2'b10));
    respond(1, 0, 0);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_gnt", 128'(gnt), 128'(2'b00));
    checkOutput("rst_stb", 128'(s_bus.stb), 128'(1'b0));
    checkOutput("rst_ack", 128'(m1_bus.ack), 128'(1'b0));
    respond(0, 0, 0);
    applyStimulus(0, 1, 1, 0, 32'h9000);
    step(1);
    rst_n = 1'b1;
    step(2);
    checkOutput("post_rst_tie", 128'(gnt), 128'(2'b01));
    applyStimulus(0, 0, 0, 0, 32'h0);
    applyStimulus(1, 0, 0, 0, 32'h0);
    step(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_ssram_arb.md
WB_SSRAM_ARB -- requirements
Module: wb_ssram_arb

Interface
REQ-001 Parameter TMO_W, default 8: width of the transfer timeout counter; timeout fires at 2^TMO_W-1 stalled cycles.
REQ-002 One clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 m0_adr/m1_adr  in  32  master N address.
REQ-006 m0_din/m1_din  in  32  master N write data.
REQ-007 m0_sel/m1_sel  in  4  master N byte enables.
REQ-008 m0_cyc, m0_stb, m0_we / m1_cyc, m1_stb, m1_we  in  1 each  master N cycle, strobe, write enable.
REQ-009 m0_dout/m1_dout  out  32  read data; both driven from s_dout.
REQ-010 m0_ack, m0_err, m0_rty / m1_ack, m1_err, m1_rty  out  1 each  master N termination.
REQ-011 s_adr  out  32,  s_din  out  32,  s_sel  out  4,  s_cyc/s_stb/s_we  out  1: to SSRAM Wishbone slave.
REQ-012 s_dout  in  32,  s_ack/s_err/s_rty  in  1: from SSRAM Wishbone slave.
REQ-013 gnt  out  2  one-hot current grant (bit N = master N); 2'b00 when none.

Function
REQ-014 States: IDLE, BUSY, DRAIN; gnt and last-served pointer (last) are registers.
REQ-015 IDLE: request N = mN_cyc & mN_stb; single request -> grant it; both -> grant master != last; none -> stay IDLE, gnt=00.
REQ-016 Grant latency: gnt set and state=BUSY one clk after request sampled in IDLE.
REQ-017 BUSY: s_adr, s_din, s_sel, s_we, s_cyc, s_stb combinationally muxed from granted master; non-granted master inputs ignored.
REQ-018 Outside BUSY: s_cyc=0, s_stb=0, s_we=0, s_adr=0, s_din=0, s_sel=0.
REQ-019 s_ack/s_err/s_rty routed combinationally (zero latency) to granted master only; non-granted master ack/err/rty=0 at all times.
REQ-020 Grant held (Wishbone cyc lock) while granted mN_cyc=1, across multiple strobed transfers.
REQ-021 BUSY and granted mN_cyc=0 -> next clk IDLE, gnt=00, last=N; other master's pending request served after one IDLE cycle.
REQ-022 Timeout counter (TMO_W bits): cleared on entry to BUSY and on any slave termination; increments each BUSY cycle with granted stb=1 and no slave termination.
REQ-023 Counter reaching 2^TMO_W-1: registered one-cycle err pulse to granted master, next state DRAIN, counter cleared.
REQ-024 DRAIN: slave cyc/stb forced 0, gnt retained, slave terminations not forwarded; exit to IDLE (last=granted, gnt=00) on s_ack|s_err|s_rty or when counter again reaches 2^TMO_W-1.
REQ-025 Simultaneous slave termination and timeout in same cycle: termination wins, no err pulse, counter cleared.
REQ-026 Master dropping cyc in same cycle as slave ack: ack still delivered, then release per REQ-021.
REQ-027 Request asserted during BUSY/DRAIN by non-granted master: held pending, no ack, served per REQ-015.

Reset
REQ-028 rst_n=0, any state: state=IDLE, gnt=00, last=1 (master 0 wins first tie), counter=0, timeout err pulse=0.
REQ-029 During reset all s_* outputs 0 and all mN_ack/err/rty=0; mid-transfer reset aborts without termination to any master.
REQ-030 First grant possible on the second clk edge after rst_n rises.

Verification
REQ-031 m0 read adr=0x100 alone -> gnt=01 one clk later, s_adr=0x100, slave ack reaches m0_ack same cycle, m1_ack=0.
REQ-032 m0,m1 request same cycle after reset -> m0 granted; after m0 drops cyc, m1 granted; repeat both -> m0 again (alternation).
REQ-033 m1 holds cyc for 3 back-to-back writes while m0 requests -> gnt stays 10 for all 3 acks, m0 granted only after m1 cyc=0.
REQ-034 TMO_W=4, slave never acks -> m0_err one-cycle pulse after 15 stalled cycles, DRAIN 15 cycles, then IDLE, gnt=00.
REQ-035 s_ack arrives on the cycle counter hits 15 -> m0_ack=1, m0_err=0, state IDLE/BUSY per cyc.
REQ-036 rst_n low mid-BUSY -> gnt=00, s_stb=0 immediately; after release, fresh tie grants m0.
